cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares one word-serial memory port between two cache refill/writeback interfaces (port 0: instruction cache, port 1: data cache). It accepts line-read (refill) and line-write (writeback) requests in the same rd_*/wr_* handshake the cache exposes, and serialises each request into WORDS_PER_LINE single-word memory transactions. It sits between the caches and the memory/bus bridge, with one line transaction in flight at a time.

## Interface
- BYTES_PER_LINE, 64, line size in bytes; power of two, ≥8.
- OFFSET_WIDTH, $clog2(BYTES_PER_LINE), line offset bits.
- WORDS_PER_LINE, BYTES_PER_LINE/4, beats per line.
- LINE_WIDTH, WORDS_PER_LINE*32, writeback line width.

Ports:
- clk_g  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- rd_req  in  2  refill request, bit p = port p; held until accepted.
- rd_addr  in  64  refill address; port p in [32p+31:32p].
- rd_rdy  out  2  refill accept; a request is accepted when rd_req[p] && rd_rdy[p].
- ret_valid  out  2  returned refill word valid, per port.
- ret_last  out  2  final refill word, per port; qualified by ret_valid.
- ret_data  out  32  returned word, shared by both ports.
- wr_req  in  2  writeback request, held until accepted.
- wr_addr  in  64  writeback address, packed as rd_addr.
- wr_data  in  2*LINE_WIDTH  writeback line; word k of port p in [p*LINE_WIDTH+32k +: 32].
- wr_rdy  out  2  writeback accept.
- mem_req  out  1  memory word request; held until mem_addr_ok.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; always 4'b1111 on writes and 4'b0000 on reads.
- mem_addr_ok  in  1  request accepted this cycle.
- mem_data_ok  in  1  read data / write ack this cycle.
- mem_rdata  in  32  read data.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA.
- Registers: owner (1b), rw (1b), base address (32b, offset bits forced to 0), beat counter (OFFSET_WIDTH-2 bits), latched line (LINE_WIDTH), rr (1b, last read grant).
- Arbitration, evaluated only in IDLE, fixed order:
  1. wr_req[1]
  2. wr_req[0]
  3. reads
- Reads are round-robin. If both rd_req bits are set, grant port ~rr. A single requester is always granted. rr is updated to the granted port.
- Exactly one rd_rdy/wr_rdy bit is high, and only for the winner, combinationally in IDLE. All ready bits are 0 in other states and while resetn is low.
- Accept (IDLE):
  - Latch owner and base.
  - On a write, also latch the owner's line.
  - Clear the beat counter.
  - Next state is RD_ADDR or WR_ADDR.
- RD_ADDR / WR_ADDR:
  - mem_req=1, mem_wr=rw, mem_addr = base + 4·count.
  - mem_wdata = latched word[count] on writes, 0 on reads.
  - On mem_addr_ok, go to RD_DATA / WR_DATA.
- RD_DATA: ret_valid[owner] = mem_data_ok, ret_data = mem_rdata, and ret_last[owner] = mem_data_ok && count == WORDS_PER_LINE-1 (combinational pass-through).
- WR_DATA: mem_data_ok completes the beat; no cache-side output.
- On mem_data_ok:
  - If count == WORDS_PER_LINE-1, go to IDLE.
  - Otherwise increment count and return to the *_ADDR state.
- Counter arithmetic wraps modulo WORDS_PER_LINE. Address increment never carries into the index/tag bits.
- mem_data_ok in IDLE or *_ADDR is a protocol error and is ignored. mem_addr_ok outside *_ADDR is ignored.
- Because writes win over reads and transactions do not overlap, a writeback issued before a refill is always fully acked before that refill starts.

## Timing
- Reset values:
  - State IDLE, rr=1 (port 0 wins the first read tie), count 0.
  - mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - ret_valid=0, ret_last=0, ret_data=0.
- Reset mid-transaction aborts immediately: the next cycle is IDLE with mem_req=0. No further ret_valid is produced.
- Accept cycle T: mem_req=1 first at T+1.
- Each beat takes at least 2 cycles (addr_ok in the request's first cycle, data_ok the following cycle).
- A full line takes at least 2·WORDS_PER_LINE cycles after T+1.
- IDLE is re-entered the cycle after the last mem_data_ok. A new accept is possible in that same cycle, so mem_req rises 2 cycles after the last data_ok.
- mem_req, mem_addr, mem_wr and mem_wdata are stable while mem_req=1 and mem_addr_ok=0.

## Test plan
- **Single refill.** rd_req=01, rd_addr[31:0]=0x1000_0044. Memory model: addr_ok immediate, data_ok +1, rdata=addr.
  - Required: 16 reads at 0x1000_0040..0x1000_007C.
  - ret_valid[0] 16 times with ret_data equal to each address.
  - ret_last[0] only on 0x1000_007C.
  - IDLE at T+33.
- **Writeback.** wr_req=10, wr_addr[63:32]=0x2000_0000, word k=0xA000_0000+k.
  - Required: 16 writes, mem_wr=1, wstrb=1111.
  - mem_addr 0x2000_0000+4k, mem_wdata 0xA000_0000+k in order.
  - No ret_valid.
- **Priority.** rd_req=01 and wr_req=10 asserted the same cycle.
  - Required: wr_rdy=10 first.
  - rd_rdy[0] rises only in the IDLE cycle after the 16th write ack.
- **Round-robin.** rd_req=11 held for three grants.
  - Required: grant order port0, port1, port0.
  - ret_valid only ever on the owning bit.
- **Backpressure.** mem_addr_ok delayed 3 cycles and data_ok delayed 2 cycles on every beat.
  - Required: mem_req and mem_addr are held constant across stalls.
  - The line completes with correct data; spurious data_ok during *_ADDR is ignored.
- **Reset mid-burst.** resetn=0 for 1 cycle after beat 5 of a refill.
  - Required: next cycle is IDLE with mem_req=0 and ret_valid=0.
  - A new refill then starts at count 0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one word-serial memory port between the I-cache (port 0) and D-cache (port 1),
// breaking each line refill or writeback into WORDS_PER_LINE single-word transactions.
module cache_mem_arbiter #(
    parameter int unsigned BYTES_PER_LINE = 64,
    parameter int unsigned OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
    parameter int unsigned WORDS_PER_LINE = BYTES_PER_LINE / 4,
    parameter int unsigned LINE_WIDTH     = WORDS_PER_LINE * 32
) (
    input  logic                    clk_g,
    input  logic                    resetn,

    input  logic [1:0]              rd_req,
    input  logic [63:0]             rd_addr,
    output logic [1:0]              rd_rdy,
    output logic [1:0]              ret_valid,
    output logic [1:0]              ret_last,
    output logic [31:0]             ret_data,

    input  logic [1:0]              wr_req,
    input  logic [63:0]             wr_addr,
    input  logic [2*LINE_WIDTH-1:0] wr_data,
    output logic [1:0]              wr_rdy,

    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    input  logic [31:0]             mem_rdata
);

    localparam int unsigned   CW          = OFFSET_WIDTH - 2;
    localparam logic [CW-1:0] LAST_BEAT   = CW'(WORDS_PER_LINE - 1);
    localparam logic [31:0]   OFFSET_MASK = 32'((64'd1 << OFFSET_WIDTH) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rw_q, rw_d;
    logic                  rr_q, rr_d;
    logic [31:0]           base_q, base_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;

    logic                  grant_vld;
    logic                  grant_wr;
    logic                  grant_port;
    logic [63:0]           grant_addr_pair;
    logic [31:0]           grant_addr;
    logic [31:0]           beat_addr;
    logic [31:0]           beat_wdata;

    // Writebacks (port 1 first) always beat refills; refill ties alternate via rr.
    always_comb begin
        grant_vld  = 1'b1;
        grant_wr   = 1'b0;
        grant_port = 1'b0;
        if (wr_req[1]) begin
            grant_wr   = 1'b1;
            grant_port = 1'b1;
        end else if (wr_req[0]) begin
            grant_wr   = 1'b1;
            grant_port = 1'b0;
        end else if (&rd_req) begin
            grant_port = ~rr_q;
        end else if (rd_req[0]) begin
            grant_port = 1'b0;
        end else if (rd_req[1]) begin
            grant_port = 1'b1;
        end else begin
            grant_vld  = 1'b0;
        end
    end

    assign grant_addr_pair = grant_wr ? wr_addr : rd_addr;
    assign grant_addr      = grant_port ? grant_addr_pair[63:32] : grant_addr_pair[31:0];

    // OR rather than add so the beat offset can never carry into the index/tag bits.
    assign beat_addr  = base_q | {{(32-OFFSET_WIDTH){1'b0}}, cnt_q, 2'b00};
    assign beat_wdata = line_q[{cnt_q, 5'b00000} +: 32];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rw_d      = rw_q;
        rr_d      = rr_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        rd_rdy    = '0;
        wr_rdy    = '0;
        ret_valid = '0;
        ret_last  = '0;
        ret_data  = '0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;

        if (resetn) begin
            unique case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        if (grant_wr) begin
                            wr_rdy[grant_port] = 1'b1;
                            line_d  = grant_port ? wr_data[2*LINE_WIDTH-1:LINE_WIDTH]
                                                 : wr_data[LINE_WIDTH-1:0];
                            state_d = WR_ADDR;
                        end else begin
                            rd_rdy[grant_port] = 1'b1;
                            rr_d    = grant_port;
                            state_d = RD_ADDR;
                        end
                        owner_d = grant_port;
                        rw_d    = grant_wr;
                        base_d  = grant_addr & ~OFFSET_MASK;
                        cnt_d   = '0;
                    end
                end

                RD_ADDR, WR_ADDR: begin
                    mem_req   = 1'b1;
                    mem_wr    = rw_q;
                    mem_addr  = beat_addr;
                    mem_wdata = rw_q ? beat_wdata : '0;
                    mem_wstrb = rw_q ? '1 : '0;
                    if (mem_addr_ok) begin
                        state_d = rw_q ? WR_DATA : RD_DATA;
                    end
                end

                RD_DATA, WR_DATA: begin
                    if (!rw_q) begin
                        ret_valid[owner_q] = mem_data_ok;
                        ret_last[owner_q]  = mem_data_ok && (cnt_q == LAST_BEAT);
                        ret_data           = mem_rdata;
                    end
                    if (mem_data_ok) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = rw_q ? WR_ADDR : RD_ADDR;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            rr_q    <= 1'b1;
            base_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            rr_q    <= rr_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a memory responder with programmable stalls and
// scoreboards of expected memory beats and returned refill words.
module tb_cache_mem_arbiter;

    localparam int unsigned BPL = 64;
    localparam int unsigned WPL = 16;
    localparam int unsigned LW  = 512;

    logic            clk_g = 1'b0;
    logic            resetn;
    logic [1:0]      rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
    logic [63:0]     rd_addr, wr_addr;
    logic [31:0]     ret_data;
    logic [2*LW-1:0] wr_data;
    logic            mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_wstrb;

    always #5 clk_g = ~clk_g;

    cache_mem_arbiter #(.BYTES_PER_LINE(BPL)) dut (
        .clk_g(clk_g), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } mop_t;
    typedef struct { logic [1:0] vld; logic [1:0] last; logic [31:0] data; } ret_t;

    mop_t mem_q[$];
    ret_t ret_q[$];
    int   checks = 0;
    int   errors = 0;

    int          ad_delay = 0;
    int          dd_delay = 0;
    bit          spurious = 0;
    bit          pend = 0;
    int          dcnt = 0;
    int          acnt = 0;
    int          ret_cnt = 0;
    logic [31:0] pend_addr;
    logic        pend_wr;
    bit          held_valid = 0;
    logic [31:0] held_addr, held_wdata;
    logic        held_wr;
    bit          take, stall, exp_ret;
    mop_t        e;
    ret_t        r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_g);
        #1;
    endtask

    task automatic push_refill(input int port, input logic [31:0] addr);
        logic [31:0] base;
        base = addr & ~32'h3F;
        for (int k = 0; k < WPL; k++) begin
            mem_q.push_back('{1'b0, base + 32'(4 * k), 32'h0});
            ret_q.push_back('{2'(1 << port), (k == WPL - 1) ? 2'(1 << port) : 2'b00,
                              base + 32'(4 * k)});
        end
    endtask

    task automatic push_wb(input logic [31:0] base, input logic [31:0] word0);
        for (int k = 0; k < WPL; k++)
            mem_q.push_back('{1'b1, base + 32'(4 * k), word0 + 32'(k)});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((mem_q.size() != 0 || ret_q.size() != 0 || pend || mem_req !== 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 3000), 64'd1);
    endtask

    // Memory responder: drives handshakes on the falling edge and checks 2 time units later.
    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        forever begin
            @(negedge clk_g);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            take = 0; stall = 0; exp_ret = 0;
            if (!resetn) begin
                pend = 0; acnt = 0; held_valid = 0;
            end else if (pend) begin
                if (dcnt == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = pend_addr;
                    exp_ret     = !pend_wr;
                    pend        = 0;
                end else begin
                    dcnt--;
                end
            end else if (mem_req === 1'b1) begin
                if (acnt == ad_delay) begin
                    mem_addr_ok = 1'b1;
                    take = 1;
                end else begin
                    if (spurious && acnt == 1) begin
                        mem_data_ok = 1'b1;
                        mem_rdata   = 32'hDEAD_BEEF;
                    end
                    acnt++;
                    stall = 1;
                end
            end
            #2;
            if (take) begin
                checks++;
                assert (mem_q.size() != 0) else begin
                    errors++;
                    $error("FAIL mem_extra_req: observed addr %0h expected no request", mem_addr);
                end
                if (mem_q.size() != 0) begin
                    e = mem_q.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("mem_wr", 64'(mem_wr), 64'(e.wr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    chk("mem_wstrb", 64'(mem_wstrb), e.wr ? 64'hF : 64'h0);
                    pend_addr = e.addr;
                end else begin
                    pend_addr = mem_addr;
                end
                pend = 1; pend_wr = mem_wr; dcnt = dd_delay; acnt = 0; held_valid = 0;
            end
            if (stall) begin
                if (held_valid) begin
                    chk("hold_addr", 64'(mem_addr), 64'(held_addr));
                    chk("hold_wr", 64'(mem_wr), 64'(held_wr));
                    chk("hold_wdata", 64'(mem_wdata), 64'(held_wdata));
                end else begin
                    held_addr = mem_addr; held_wr = mem_wr; held_wdata = mem_wdata;
                    held_valid = 1;
                end
            end
            if (exp_ret) begin
                ret_cnt++;
                checks++;
                assert (ret_q.size() != 0) else begin
                    errors++;
                    $error("FAIL ret_extra: observed ret_valid %0h expected none", ret_valid);
                end
                if (ret_q.size() != 0) begin
                    r = ret_q.pop_front();
                    chk("ret_valid", 64'(ret_valid), 64'(r.vld));
                    chk("ret_last", 64'(ret_last), 64'(r.last));
                    chk("ret_data", 64'(ret_data), 64'(r.data));
                end
            end else begin
                chk("ret_valid_quiet", 64'(ret_valid), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn  = 1'b0;
        rd_req  = 2'b11;
        wr_req  = 2'b11;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) tick();
        chk("rst_rd_rdy", 64'(rd_rdy), 64'd0);
        chk("rst_wr_rdy", 64'(wr_rdy), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_ret_last", 64'(ret_last), 64'd0);
        chk("rst_ret_data", 64'(ret_data), 64'd0);
        rd_req = 2'b00;
        wr_req = 2'b00;
        resetn = 1'b1;
        tick();

        // Single refill, port 0
        rd_addr[31:0] = 32'h1000_0044;
        rd_req = 2'b01;
        #1;
        chk("refill_rd_rdy", 64'(rd_rdy), 64'd1);
        push_refill(0, 32'h1000_0044);
        tick();
        rd_req = 2'b00;
        chk("refill_req_t1", 64'(mem_req), 64'd1);
        chk("refill_addr_t1", 64'(mem_addr), 64'h1000_0040);
        repeat (30) tick();
        chk("refill_req_t31", 64'(mem_req), 64'd1);
        chk("refill_addr_t31", 64'(mem_addr), 64'h1000_007C);
        tick();
        rd_req = 2'b01;
        #1;
        chk("refill_busy_t32", 64'(rd_rdy), 64'd0);
        tick();
        chk("refill_idle_t33", 64'(rd_rdy), 64'd1);
        rd_req = 2'b00;
        wait_done("refill_done");

        // Writeback, port 1; port 0 line differs so a wrong latch is visible
        wr_addr[63:32] = 32'h2000_0000;
        for (int k = 0; k < WPL; k++) begin
            wr_data[LW + 32 * k +: 32] = 32'hA000_0000 + 32'(k);
            wr_data[32 * k +: 32]      = 32'h5555_0000 + 32'(k);
        end
        wr_req = 2'b10;
        #1;
        chk("wb_wr_rdy", 64'(wr_rdy), 64'h2);
        chk("wb_rd_rdy", 64'(rd_rdy), 64'd0);
        push_wb(32'h2000_0000, 32'hA000_0000);
        tick();
        wr_req  = 2'b00;
        wr_data = '1;
        wait_done("wb_done");

        // Priority: writeback beats a simultaneous refill
        rd_addr[31:0]  = 32'h3000_0000;
        wr_addr[63:32] = 32'h4000_0000;
        for (int k = 0; k < WPL; k++)
            wr_data[LW + 32 * k +: 32] = 32'hC000_0000 + 32'(k);
        rd_req = 2'b01;
        wr_req = 2'b10;
        #1;
        chk("prio_wr_rdy", 64'(wr_rdy), 64'h2);
        chk("prio_rd_rdy_low", 64'(rd_rdy), 64'd0);
        push_wb(32'h4000_0000, 32'hC000_0000);
        push_refill(0, 32'h3000_0000);
        tick();
        wr_req = 2'b00;
        n = 1;
        while (rd_rdy === 2'b00 && n < 200) begin
            tick();
            n++;
        end
        chk("prio_rd_rdy_cycle", 64'(n), 64'd33);
        chk("prio_rd_rdy", 64'(rd_rdy), 64'd1);
        tick();
        rd_req = 2'b00;
        wait_done("prio_done");

        // Reset in idle restores rr so port 0 wins the first tie
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Round-robin over three grants
        rd_addr = {32'h6000_0000, 32'h5000_0000};
        push_refill(0, 32'h5000_0000);
        push_refill(1, 32'h6000_0000);
        push_refill(0, 32'h5000_0000);
        rd_req = 2'b11;
        #1;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            while (rd_rdy === 2'b00 && n < 200) begin
                tick();
                n++;
            end
            chk("rr_grant", 64'(rd_rdy), (g == 1) ? 64'h2 : 64'h1);
            tick();
            if (g == 2) rd_req = 2'b00;
        end
        wait_done("rr_done");

        // Backpressure with spurious data_ok during the address phase
        ad_delay = 3;
        dd_delay = 2;
        spurious = 1;
        rd_addr[63:32] = 32'h7000_0010;
        rd_req = 2'b10;
        #1;
        chk("bp_rd_rdy", 64'(rd_rdy), 64'h2);
        push_refill(1, 32'h7000_0010);
        tick();
        rd_req = 2'b00;
        wait_done("bp_refill_done");
        wr_addr[31:0] = 32'h8000_0000;
        for (int k = 0; k < WPL; k++)
            wr_data[32 * k +: 32] = 32'hB000_0000 + 32'(k);
        wr_req = 2'b01;
        #1;
        chk("bp_wr_rdy", 64'(wr_rdy), 64'h1);
        push_wb(32'h8000_0000, 32'hB000_0000);
        tick();
        wr_req = 2'b00;
        wait_done("bp_wb_done");
        ad_delay = 0;
        dd_delay = 0;
        spurious = 0;

        // Reset after beat 5 of a refill
        rd_addr[31:0] = 32'h9000_0000;
        rd_req = 2'b01;
        #1;
        push_refill(0, 32'h9000_0000);
        n = ret_cnt;
        tick();
        rd_req = 2'b00;
        while (ret_cnt - n < 5 && ret_cnt - n >= 0 && $time < 150000) tick();
        chk("mid_beats_seen", 64'(ret_cnt - n), 64'd5);
        resetn = 1'b0;
        mem_q.delete();
        ret_q.delete();
        tick();
        resetn = 1'b1;
        chk("mid_mem_req", 64'(mem_req), 64'd0);
        chk("mid_ret_valid", 64'(ret_valid), 64'd0);
        chk("mid_rd_rdy", 64'(rd_rdy), 64'd0);
        rd_addr[31:0] = 32'hA000_0004;
        rd_req = 2'b01;
        #1;
        chk("mid_restart_rdy", 64'(rd_rdy), 64'd1);
        push_refill(0, 32'hA000_0004);
        tick();
        rd_req = 2'b00;
        chk("mid_restart_addr", 64'(mem_addr), 64'hA000_0000);
        wait_done("mid_restart_done");

        chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
        chk("ret_q_drained", 64'(ret_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
